multi_servo_pwm: RTL and testbench
==================================

Name: multi_servo_pwm

Overview:
- Multi-channel servo pulse generator; next generation of the single-channel servo driver.
- Generates NUM_CH phase-aligned servo PWM outputs sharing one frame counter.
- Each channel has a write port for position, a shadow register, optional per-frame slew limiting and a per-channel enable.
- Position updates apply only at frame boundaries, so no runt or stretched pulses occur.
- Sits between the control logic (register file / CPU writes) and the servo pins.

Parameters:
- NUM_CH, 4, number of servo channels (1..16).
- SYS_FREQ_MHZ, 25, clk frequency in MHz.
- PERIOD_US, 20000, frame period in microseconds.
- MIN_PULSE_US, 1000, pulse width for position 0.
- MAX_PULSE_US, 2000, full-scale pulse width reference.
- POS_WIDTH, 10, position word width.
- RESET_POS, 512, shadow/active position after reset.
- SLEW_STEP, 0, max change of the active position per frame, in position LSBs; 0 means no limit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- wr_en  in  1  position write strobe, single cycle.
- wr_ch  in  CH_W=max(1,$clog2(NUM_CH))  target channel.
- wr_pos  in  POS_WIDTH  new position.
- ch_enable  in  NUM_CH  per-channel output enable.
- servo_out  out  NUM_CH  PWM outputs, registered.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Derived constants:
  - PERIOD_TICKS=PERIOD_US*SYS_FREQ_MHZ.
  - MIN_TICKS=MIN_PULSE_US*SYS_FREQ_MHZ.
  - SPAN=(MAX_PULSE_US-MIN_PULSE_US)*SYS_FREQ_MHZ.
  - Elaboration error unless MIN_PULSE_US<MAX_PULSE_US<PERIOD_US.
- Frame counter cnt, width $clog2(PERIOD_TICKS): counts 0..PERIOD_TICKS-1, then wraps to 0.
- Reset takes priority over everything and completes in one cycle:
  - cnt=0; shadow[i]=active[i]=RESET_POS; en_act=0; servo_out=0; frame_start=0.
  - A reset mid-pulse forces servo_out low on the next edge.
- Write handling:
  - wr_en=1 with wr_ch<NUM_CH: shadow[wr_ch]<=wr_pos.
  - wr_ch>=NUM_CH: write ignored.
  - Writes are accepted every cycle; last write before the boundary wins.
- Frame boundary (cnt==PERIOD_TICKS-1), per channel:
  - en_act[i]<=ch_enable[i].
  - If SLEW_STEP==0: active[i]<=shadow[i].
  - Otherwise, if |shadow-active|<=SLEW_STEP, active<=shadow; else active moves SLEW_STEP toward shadow.
  - A write in the same cycle as the boundary is not seen; it applies at the next boundary.
- Pulse width per channel: width[i]=MIN_TICKS+((active[i]*SPAN)>>POS_WIDTH).
  - Unsigned arithmetic; product width POS_WIDTH+$clog2(SPAN+1).
  - width[i] is stable for the whole frame.
- Output timing:
  - servo_out[i]<=en_act[i] && (cnt<width[i]), registered.
  - servo_out rises one cycle after cnt==0 and stays high exactly width[i] cycles.
  - Channels are phase-aligned.
- frame_start<=(cnt==0), registered, so it is coincident with the servo_out rising edge.
- Disabling a channel mid-frame does not truncate the current pulse; output goes low from the next frame.
- Enable transitions therefore never produce partial pulses.

Test Plan:
- Default params, no writes: after reset deassert, servo_out[0..3] high for 37500 cycles, period 500000 cycles; frame_start pulses every 500000 cycles.
- Position boundaries: write ch1=0 and ch2=1023 mid-frame → current frame still 37500 cycles; next frame ch1 high 25000 cycles, ch2 high 49975 cycles.
- Write timing and channel range:
  - Write ch0=100 on the cnt==PERIOD_TICKS-1 cycle → takes effect one frame later (width 27441).
  - Write with wr_ch=5 when NUM_CH=4 → no channel changes.
- SLEW_STEP=100, ch0 at 512, write 900 → active 612, 712, 812, 900 over four frames; widths 39941, 42382, 44824, 46972.
- ch_enable[3] dropped mid-pulse → current pulse completes at full width; next frame ch3 low. Re-enabled → full pulse from the following frame, never partial.
- Reset asserted mid-pulse for 1 cycle → servo_out all 0 next edge; cnt restarts; widths return to 37500.

Source files
------------

// File: rtl/multi_servo_pwm.sv
// Multi-channel servo PWM generator: shared frame counter, per-channel
// shadow/active positions with optional slew limit, frame-aligned updates.
module multi_servo_pwm #(
    parameter int NUM_CH       = 4,
    parameter int SYS_FREQ_MHZ = 25,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 1000,
    parameter int MAX_PULSE_US = 2000,
    parameter int POS_WIDTH    = 10,
    parameter int RESET_POS    = 512,
    parameter int SLEW_STEP    = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [POS_WIDTH-1:0] wr_pos,
    input  logic [NUM_CH-1:0]    ch_enable,
    output logic [NUM_CH-1:0]    servo_out,
    output logic                 frame_start
);

    localparam int PERIOD_TICKS = PERIOD_US * SYS_FREQ_MHZ;
    localparam int MIN_TICKS    = MIN_PULSE_US * SYS_FREQ_MHZ;
    localparam int SPAN         = (MAX_PULSE_US - MIN_PULSE_US) * SYS_FREQ_MHZ;
    localparam int CNT_W        = $clog2(PERIOD_TICKS);
    localparam int SPAN_W       = $clog2(SPAN + 1);
    localparam int PROD_W       = POS_WIDTH + SPAN_W;
    localparam int PW1          = POS_WIDTH + 1;

    localparam logic [CNT_W-1:0]     LAST    = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [POS_WIDTH-1:0] RST_POS = POS_WIDTH'(RESET_POS);
    localparam logic [PW1-1:0]       STEP    = PW1'(SLEW_STEP);

    if (!(MIN_PULSE_US < MAX_PULSE_US && MAX_PULSE_US < PERIOD_US)) begin : g_bad_timing
        $error("multi_servo_pwm: need MIN_PULSE_US < MAX_PULSE_US < PERIOD_US");
    end

    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [NUM_CH-1:0][POS_WIDTH-1:0]  shadow_q, shadow_d;
    logic [NUM_CH-1:0][POS_WIDTH-1:0]  active_q, active_d;
    logic [NUM_CH-1:0]                 en_act_q, en_act_d;
    logic [NUM_CH-1:0]                 servo_q, servo_d;
    logic                              frame_start_q, frame_start_d;
    logic                              boundary;
    logic [NUM_CH-1:0][CNT_W-1:0]      width;

    // Move cur toward tgt by at most SLEW_STEP; zero step means jump.
    function automatic logic [POS_WIDTH-1:0] slew_to(
        input logic [POS_WIDTH-1:0] tgt,
        input logic [POS_WIDTH-1:0] cur
    );
        logic [PW1-1:0] t;
        logic [PW1-1:0] c;
        t = {1'b0, tgt};
        c = {1'b0, cur};
        if (SLEW_STEP == 0) begin
            return tgt;
        end
        if (t >= c) begin
            if ((t - c) <= STEP) begin
                return tgt;
            end
            return POS_WIDTH'(c + STEP);
        end
        if ((c - t) <= STEP) begin
            return tgt;
        end
        return POS_WIDTH'(c - STEP);
    endfunction

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PROD_W-1:0] prod;
        assign prod     = PROD_W'(active_q[g]) * PROD_W'(SPAN);
        assign width[g] = CNT_W'(MIN_TICKS) + CNT_W'(prod >> POS_WIDTH);
    end

    always_comb begin
        boundary      = (cnt_q == LAST);
        cnt_d         = boundary ? '0 : cnt_q + 1'b1;
        shadow_d      = shadow_q;
        active_d      = active_q;
        en_act_d      = en_act_q;
        servo_d       = '0;
        frame_start_d = (cnt_q == '0);

        if (wr_en && (int'(wr_ch) < NUM_CH)) begin
            shadow_d[wr_ch] = wr_pos;
        end

        // Boundary uses the old shadow, so a same-cycle write waits a frame.
        if (boundary) begin
            en_act_d = ch_enable;
            for (int i = 0; i < NUM_CH; i++) begin
                active_d[i] = slew_to(shadow_q[i], active_q[i]);
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            servo_d[i] = en_act_q[i] && (cnt_q < width[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            shadow_q      <= {NUM_CH{RST_POS}};
            active_q      <= {NUM_CH{RST_POS}};
            en_act_q      <= '0;
            servo_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            en_act_q      <= en_act_d;
            servo_q       <= servo_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign servo_out   = servo_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_multi_servo_pwm.sv
// Bench for multi_servo_pwm: a jump-mode and a slew-limited instance on
// a short frame, compared every cycle against a frame-level model.
module tb_multi_servo_pwm;

    localparam int NCH    = 5;
    localparam int FREQ   = 1;
    localparam int PER    = 300;
    localparam int MINP   = 50;
    localparam int MAXP   = 150;
    localparam int PW     = 10;
    localparam int RPOS   = 512;
    localparam int STEP_B = 100;
    localparam int P      = PER * FREQ;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_en = 1'b0;
    logic [2:0]      wr_ch = '0;
    logic [PW-1:0]   wr_pos = '0;
    logic [NCH-1:0]  ch_enable = '1;
    logic [NCH-1:0]  out_a, out_b;
    logic            fs_a, fs_b;

    always #5 clk = ~clk;

    multi_servo_pwm #(
        .NUM_CH(NCH), .SYS_FREQ_MHZ(FREQ), .PERIOD_US(PER),
        .MIN_PULSE_US(MINP), .MAX_PULSE_US(MAXP), .POS_WIDTH(PW),
        .RESET_POS(RPOS), .SLEW_STEP(0)
    ) u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pos(wr_pos), .ch_enable(ch_enable),
        .servo_out(out_a), .frame_start(fs_a)
    );

    multi_servo_pwm #(
        .NUM_CH(NCH), .SYS_FREQ_MHZ(FREQ), .PERIOD_US(PER),
        .MIN_PULSE_US(MINP), .MAX_PULSE_US(MAXP), .POS_WIDTH(PW),
        .RESET_POS(RPOS), .SLEW_STEP(STEP_B)
    ) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_pos(wr_pos), .ch_enable(ch_enable),
        .servo_out(out_b), .frame_start(fs_b)
    );

    int checks = 0;
    int errors = 0;

    int m_phase = 0;
    int sh [2][NCH];
    int ac [2][NCH];
    bit en [2][NCH];
    int fh [2][NCH];
    int hc [2][NCH];
    logic [NCH-1:0] eo [2];
    logic efs;

    function automatic int wfn(input int pos, input int minp, input int maxp,
                               input int f, input int pw);
        return minp * f + (pos * (maxp - minp) * f) / (1 << pw);
    endfunction

    function automatic int slew(input int tgt, input int cur, input int step);
        int diff;
        diff = tgt - cur;
        if (step == 0) return tgt;
        if (diff <= step && diff >= -step) return tgt;
        return (diff > 0) ? cur + step : cur - step;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset) begin
            efs = 1'b0;
            m_phase = 0;
            for (int d = 0; d < 2; d++) begin
                eo[d] = '0;
                for (int c = 0; c < NCH; c++) begin
                    sh[d][c] = RPOS;
                    ac[d][c] = RPOS;
                    en[d][c] = 1'b0;
                end
            end
        end else begin
            efs = (m_phase == 0);
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NCH; c++)
                    eo[d][c] = en[d][c] &&
                               (m_phase < wfn(ac[d][c], MINP, MAXP, FREQ, PW));
            if (m_phase == P - 1) begin
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < NCH; c++) begin
                        en[d][c] = ch_enable[c];
                        ac[d][c] = slew(sh[d][c], ac[d][c], d ? STEP_B : 0);
                    end
            end
            if (wr_en && int'(wr_ch) < NCH) begin
                sh[0][wr_ch] = int'(wr_pos);
                sh[1][wr_ch] = int'(wr_pos);
            end
            m_phase = (m_phase + 1) % P;
        end

        for (int d = 0; d < 2; d++) begin
            logic [NCH-1:0] o;
            logic f;
            o = d ? out_b : out_a;
            f = d ? fs_b : fs_a;
            checks += 2;
            if (o !== eo[d]) begin
                errors++;
                $display("FAIL servo_out dut%0d t=%0t got %b want %b",
                         d, $time, o, eo[d]);
            end
            if (f !== efs) begin
                errors++;
                $display("FAIL frame_start dut%0d t=%0t got %b want %b",
                         d, $time, f, efs);
            end
            for (int c = 0; c < NCH; c++) begin
                if (f === 1'b1) begin
                    fh[d][c] = hc[d][c];
                    hc[d][c] = (o[c] === 1'b1) ? 1 : 0;
                end else begin
                    hc[d][c] += (o[c] === 1'b1) ? 1 : 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic goto_phase(input int p);
        int k;
        k = 0;
        while (m_phase != p && k < 2 * P) begin
            @(negedge clk);
            k++;
        end
        if (m_phase != p) begin
            checks++;
            errors++;
            $display("FAIL goto_phase got %0d want %0d", m_phase, p);
        end
    endtask

    task automatic next_frame();
        step(1);
        goto_phase(1);
    endtask

    task automatic write(input int ch, input int pos);
        wr_en  = 1'b1;
        wr_ch  = ch[2:0];
        wr_pos = pos[PW-1:0];
        step(1);
        wr_en  = 1'b0;
    endtask

    initial begin
        int slew_exp [5];
        slew_exp = '{109, 119, 129, 137, 137};
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
                fh[d][c] = 0;
                hc[d][c] = 0;
            end

        chk("pin_w512_default", wfn(512, 1000, 2000, 25, 10), 37500);
        chk("pin_w0_default", wfn(0, 1000, 2000, 25, 10), 25000);
        chk("pin_w1023_default", wfn(1023, 1000, 2000, 25, 10), 49975);
        chk("pin_w100_default", wfn(100, 1000, 2000, 25, 10), 27441);
        chk("pin_w612_default", wfn(612, 1000, 2000, 25, 10), 39941);
        chk("pin_w900_default", wfn(900, 1000, 2000, 25, 10), 46972);
        chk("pin_slew_up", slew(900, 512, 100), 612);
        chk("pin_slew_last", slew(900, 812, 100), 900);
        chk("pin_slew_down", slew(0, 512, 100), 412);

        step(3);
        reset = 1'b0;

        next_frame();
        next_frame();
        chk("dark_after_reset", fh[0][0], 0);
        next_frame();
        for (int c = 0; c < NCH; c++) chk($sformatf("reset_width_a%0d", c), fh[0][c], 100);
        chk("reset_width_b0", fh[1][0], 100);

        goto_phase(20);
        write(1, 0);
        write(2, 1023);
        next_frame();
        chk("midwrite_cur_ch1", fh[0][1], 100);
        chk("midwrite_cur_ch2", fh[0][2], 100);
        next_frame();
        chk("pos_min_ch1", fh[0][1], 50);
        chk("pos_max_ch2", fh[0][2], 149);

        goto_phase(P - 1);
        write(0, 100);
        next_frame();
        chk("bwrite_f0", fh[0][0], 100);
        next_frame();
        chk("bwrite_deferred", fh[0][0], 100);
        next_frame();
        chk("bwrite_applied", fh[0][0], 59);

        goto_phase(50);
        write(5, 0);
        write(7, 1023);
        next_frame();
        next_frame();
        chk("range_ch0", fh[0][0], 59);
        chk("range_ch1", fh[0][1], 50);
        chk("range_ch2", fh[0][2], 149);
        chk("range_ch3", fh[0][3], 100);
        chk("range_ch4", fh[0][4], 100);

        goto_phase(10);
        write(4, 900);
        next_frame();
        chk("slew_f0", fh[1][4], 100);
        for (int i = 0; i < 5; i++) begin
            next_frame();
            chk($sformatf("slew_f%0d", i + 1), fh[1][4], slew_exp[i]);
            if (i == 0) chk("jump_a", fh[0][4], 137);
        end

        goto_phase(40);
        ch_enable[3] = 1'b0;
        next_frame();
        chk("dis_full_a", fh[0][3], 100);
        chk("dis_full_b", fh[1][3], 100);
        next_frame();
        chk("dis_next_low", fh[0][3], 0);
        goto_phase(40);
        ch_enable[3] = 1'b1;
        next_frame();
        chk("reen_no_partial", fh[0][3], 0);
        next_frame();
        chk("reen_full", fh[0][3], 100);

        goto_phase(30);
        reset = 1'b1;
        step(1);
        chk("rst_out_a", int'(out_a), 0);
        chk("rst_out_b", int'(out_b), 0);
        chk("rst_fs", int'(fs_a), 0);
        reset = 1'b0;
        next_frame();
        next_frame();
        next_frame();
        for (int c = 0; c < NCH; c++) chk($sformatf("post_rst_a%0d", c), fh[0][c], 100);
        chk("post_rst_b4", fh[1][4], 100);

        for (int i = 0; i < 40 * P; i++) begin
            int sel;
            wr_en = ($urandom_range(0, 7) == 0);
            wr_ch = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 3);
            wr_pos = (sel == 0) ? '0 : (sel == 1) ? '1 : PW'($urandom);
            if ($urandom_range(0, 199) == 0) ch_enable = NCH'($urandom);
            reset = ($urandom_range(0, 2999) == 0);
            step(1);
        end
        reset = 1'b0;
        wr_en = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
